// File: rtl/multiplier_pkg.sv
// Shared widths for the modular multiplier datapath.
package multiplier_pkg;
  localparam int DATA_LENGTH = 32;
endpackage

// File: rtl/dilithium_mulmod_pipe_if.sv
// Operand/result bundle for dilithium_mulmod_pipe.
// Handshake: a beat moves on a side only in a cycle where that side's valid
// and ready are both 1 at the clock edge. A producer holds valid and payload
// stable until the beat moves, and ready never depends combinationally on the
// valid of the same side.
interface dilithium_mulmod_pipe_if #(
  parameter int TAG_W = 8
) ();
  logic                                  in_valid_i;
  logic                                  in_ready_o;
  logic [multiplier_pkg::DATA_LENGTH-1:0] a_i;
  logic [multiplier_pkg::DATA_LENGTH-1:0] b_i;
  logic [TAG_W-1:0]                      tag_i;
  logic                                  out_valid_o;
  logic                                  out_ready_i;
  logic [multiplier_pkg::DATA_LENGTH-1:0] result_o;
  logic [TAG_W-1:0]                      tag_o;
  logic                                  busy_o;
  logic                                  err_o;

  modport master (
    output in_valid_i, a_i, b_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, tag_o, busy_o, err_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, tag_o, busy_o, err_o
  );
endinterface

// File: rtl/dilithium_mulmod_pipe.sv
// Four-stage pipelined (a*b) mod 8380417 with valid/ready on both sides.
// S1 operand register, S2 product, S3 first fold, S4 second fold + correction.
// Optional macro MULMOD_RANGE_CHECK_EN builds a sticky flag for operands >= Q.
module dilithium_mulmod_pipe #(
  parameter int Q     = 8380417,
  parameter int TAG_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  dilithium_mulmod_pipe_if.slave bus
);
  localparam int DL = multiplier_pkg::DATA_LENGTH;
  localparam logic signed [31:0] Q_S = Q;

  // The fold identities below rely on 2^23 = 2^13 - 1 (mod Q).
  if (Q != 8380417) begin : g_bad_q
    $error("dilithium_mulmod_pipe: fold arithmetic only supports Q = 8380417");
  end

  logic             v1, v2, v3, v4;
  logic [22:0]      a1, b1;
  logic [45:0]      p2;
  logic signed [37:0] t3;
  logic [22:0]      r4;
  logic [TAG_W-1:0] tag1, tag2, tag3, tag4;
  logic             ld1, ld2, ld3, ld4, acc;

  // A stage loads when empty or when its contents move on; this ripples
  // from out_ready_i back to in_ready_o without touching in_valid_i.
  assign ld4 = !v4 || bus.out_ready_i;
  assign ld3 = !v3 || ld4;
  assign ld2 = !v2 || ld3;
  assign ld1 = !v1 || ld2;
  assign acc = bus.in_valid_i && ld1;

  logic signed [37:0] t_next;
  logic signed [31:0] th, u, uh, w, r_next;

  // First fold: p = lo + hi*2^23 -> lo + hi*(2^13 - 1).
  always_comb begin
    t_next = $signed({15'd0, p2[22:0]}) + $signed({2'd0, p2[45:23], 13'd0})
           - $signed({15'd0, p2[45:23]});
  end

  // Second fold of t. t can reach ~2^36, so one fold still leaves up to ~9Q;
  // a small fold of the few remaining top bits brings it into [0, 2Q) before
  // the single conditional correction.
  always_comb begin
    th = {{17{t3[37]}}, t3[37:23]};
    u  = $signed({9'd0, t3[22:0]}) + (th <<< 13) - th;
    uh = {{23{u[31]}}, u[31:23]};
    w  = $signed({9'd0, u[22:0]}) + (uh <<< 13) - uh;
    r_next = w;
    if (w < 0)          r_next = w + Q_S;
    else if (w >= Q_S)  r_next = w - Q_S;
  end

  logic unused_bits;
  assign unused_bits = ^{bus.a_i[DL-1:23], bus.b_i[DL-1:23], r_next[31:23]};

  // S1: capture the used operand bits and the tag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1 <= 1'b0; a1 <= '0; b1 <= '0; tag1 <= '0;
    end else if (ld1) begin
      v1 <= bus.in_valid_i;
      if (acc) begin
        a1 <= bus.a_i[22:0]; b1 <= bus.b_i[22:0]; tag1 <= bus.tag_i;
      end
    end
  end

  // S2: full 46-bit product.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v2 <= 1'b0; p2 <= '0; tag2 <= '0;
    end else if (ld2) begin
      v2 <= v1; p2 <= 46'(a1) * 46'(b1); tag2 <= tag1;
    end
  end

  // S3: first fold result.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v3 <= 1'b0; t3 <= '0; tag3 <= '0;
    end else if (ld3) begin
      v3 <= v2; t3 <= t_next; tag3 <= tag2;
    end
  end

  // S4: canonical residue; holds while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v4 <= 1'b0; r4 <= '0; tag4 <= '0;
    end else if (ld4) begin
      v4 <= v3; r4 <= r_next[22:0]; tag4 <= tag3;
    end
  end

`ifdef MULMOD_RANGE_CHECK_EN
  localparam logic [22:0] Q23 = 23'(Q);
  logic err_q;
  // Sticky flag for any accepted operand outside [0, Q).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_q <= 1'b0;
    else if (acc && (bus.a_i[22:0] >= Q23 || bus.b_i[22:0] >= Q23)) err_q <= 1'b1;
  end
  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.in_ready_o  = ld1;
  assign bus.out_valid_o = v4;
  assign bus.result_o    = DL'(r4);
  assign bus.tag_o       = tag4;
  assign bus.busy_o      = v1 | v2 | v3 | v4;
endmodule

// File: tb/tb_dilithium_mulmod_pipe.sv
// Self-checking bench for dilithium_mulmod_pipe: directed values, random
// stream against a (a*b)%Q model, stall, reset flush and range flag.
module tb_dilithium_mulmod_pipe;
  localparam int QM = 8380417;
  localparam int DL = multiplier_pkg::DATA_LENGTH;
`ifdef MULMOD_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total = 0;
  int   passed = 0;
  int   out_cnt = 0;
  logic [22:0] exp_q[$];
  logic [7:0]  tag_q[$];

  dilithium_mulmod_pipe_if #(.TAG_W(8)) bus ();

  dilithium_mulmod_pipe #(.Q(8380417), .TAG_W(8)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Clock and global time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
  endtask

  // Reference: plain modular arithmetic on the low 23 operand bits.
  function automatic logic [22:0] model(input logic [22:0] a, input logic [22:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return 23'(p % 64'(QM));
  endfunction

  // One cycle of offering an operand pair; exp_r < 0 means use the model.
  task automatic attempt(input logic [DL-1:0] a, input logic [DL-1:0] b,
                         input logic [7:0] tag, input int exp_r, output bit acc);
    bus.in_valid_i = 1'b1;
    bus.a_i = a;
    bus.b_i = b;
    bus.tag_i = tag;
    @(negedge clk);
    acc = bus.in_ready_o;
    if (acc) begin
      exp_q.push_back(exp_r < 0 ? model(a[22:0], b[22:0]) : 23'(exp_r));
      tag_q.push_back(tag);
    end
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic send(input logic [DL-1:0] a, input logic [DL-1:0] b,
                      input logic [7:0] tag, input int exp_r);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      attempt(a, b, tag, exp_r, acc);
      n++;
    end
    check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.in_valid_i = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every output transfer must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
      check("out_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("result", 64'(bus.result_o), 64'(exp_q[0]));
        check("tag", 64'(bus.tag_o), 64'(tag_q[0]));
        void'(exp_q.pop_front());
        void'(tag_q.pop_front());
      end
      out_cnt++;
    end
  end

  logic [DL-1:0] sa[8];
  logic [DL-1:0] sb[8];
  logic [DL-1:0] ra, rb;
  bit acc;
  int k, st;

  initial begin
    rst_n = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.tag_i = '0;
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state.
    check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    check("rst_result", 64'(bus.result_o), 64'd0);
    check("rst_tag", 64'(bus.tag_o), 64'd0);
    check("rst_err", 64'(bus.err_o), 64'd0);

    // Latency: output appears after the third edge following acceptance.
    attempt(DL'(0), DL'(12345), 8'h01, 0, acc);
    check("lat_acc", 64'(acc), 64'd1);
    check("lat_v_n0", 64'(bus.out_valid_o), 64'd0);
    idle(1);
    check("lat_v_n1", 64'(bus.out_valid_o), 64'd0);
    idle(1);
    check("lat_v_n2", 64'(bus.out_valid_o), 64'd0);
    idle(1);
    check("lat_v_n3", 64'(bus.out_valid_o), 64'd1);
    check("lat_result", 64'(bus.result_o), 64'd0);
    check("lat_tag", 64'(bus.tag_o), 64'h01);
    drain();

    // Directed known answers, back to back.
    send(DL'(8380416), DL'(8380416), 8'h02, 1);
    send(DL'(8380416), DL'(3), 8'h03, 8380414);
    send(DL'(4096), DL'(2048), 8'h04, 8191);
    drain();

    // Random stream, junk in the ignored upper bits.
    st = out_cnt;
    for (int i = 0; i < 16; i++) begin
      ra = DL'($urandom);
      rb = DL'($urandom);
      ra[22:0] = 23'($urandom_range(0, QM - 1));
      rb[22:0] = 23'($urandom_range(0, QM - 1));
      attempt(ra, rb, 8'(8'h10 + i), -1, acc);
      check("stream_acc", 64'(acc), 64'd1);
    end
    idle(4);
    check("stream_count", 64'(out_cnt - st), 64'd16);
    check("stream_empty", 64'(exp_q.size()), 64'd0);

    // Stall: six cycles with the consumer blocked.
    for (int i = 0; i < 8; i++) begin
      sa[i] = DL'($urandom_range(0, QM - 1));
      sb[i] = DL'($urandom_range(0, QM - 1));
    end
    st = out_cnt;
    bus.out_ready_i = 1'b0;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      attempt(sa[k], sb[k], 8'(8'h40 + k), -1, acc);
      if (acc) k++;
      if (i >= 3) begin
        check("stall_in_ready", 64'(bus.in_ready_o), 64'd0);
        check("stall_out_valid", 64'(bus.out_valid_o), 64'd1);
        check("stall_result", 64'(bus.result_o), 64'(exp_q[0]));
        check("stall_tag", 64'(bus.tag_o), 64'(tag_q[0]));
      end
    end
    check("stall_accepted", 64'(k), 64'd4);
    bus.out_ready_i = 1'b1;
    while (k < 8) begin
      send(sa[k], sb[k], 8'(8'h40 + k), -1);
      k++;
    end
    drain();
    check("stall_total", 64'(out_cnt - st), 64'd8);

    // Reset with three operations in flight.
    st = out_cnt;
    for (int i = 0; i < 3; i++) begin
      attempt(DL'($urandom_range(0, QM - 1)), DL'($urandom_range(0, QM - 1)),
              8'(8'h60 + i), -1, acc);
      check("flush_acc", 64'(acc), 64'd1);
    end
    rst_n = 1'b0;
    exp_q.delete();
    tag_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("flush_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("flush_busy", 64'(bus.busy_o), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready_o), 64'd1);
    idle(8);
    check("flush_no_stale", 64'(out_cnt - st), 64'd0);
    check("flush_err", 64'(bus.err_o), 64'd0);

    // Out-of-range operands: still reduced; flag depends on build.
    send(DL'(8388607), DL'(1), 8'h77, 8190);
    check("range_err_set", 64'(bus.err_o), 64'(RANGE_EN));
    send(DL'($urandom_range(QM, 8388607)), DL'($urandom_range(QM, 8388607)), 8'h78, -1);
    send(DL'($urandom_range(0, QM - 1)), DL'(8388607), 8'h79, -1);
    drain();
    idle(3);
    check("range_err_sticky", 64'(bus.err_o), 64'(RANGE_EN));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dilithium_mulmod_pipe.md
Name: dilithium_mulmod_pipe

Overview:
- Pipelined modular multiplier for the Dilithium field, q = 8380417 = 2^23 - 2^13 + 1.
- Producer side of the modular-reduction interface: accepts two residues, forms the 46-bit product and folds it back to a canonical residue in [0, q).
- Sits between the NTT butterfly controller (upstream) and the coefficient write-back path (downstream).
- Valid/ready on both sides, one result per cycle.

Parameters:
- Q, 8380417, field modulus; the fold arithmetic is hard-wired to this value and elaboration fails for any other value.
- TAG_W, 8, width of the sideband tag carried alongside each operation.
- DATA_LENGTH, from multiplier_pkg, width of the operand and result buses.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block can accept the operand pair this cycle.
- a_i  in  DATA_LENGTH  operand A; bits [22:0] used, upper bits ignored.
- b_i  in  DATA_LENGTH  operand B; bits [22:0] used, upper bits ignored.
- tag_i  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- result_o  out  DATA_LENGTH  (a*b) mod Q, zero-extended.
- tag_o  out  TAG_W  tag of the current result.
- busy_o  out  1  at least one stage holds a valid operation.
- err_o  out  1  sticky operand-range error (see Optional Feature).

Behaviour:
- Reset is sampled on the clock edge only. While rst_ni = 0, every stage valid bit, out_valid_o, busy_o and err_o are 0. result_o and tag_o are 0 out of reset.
- Pipeline stages:
  - S1: register a[22:0], b[22:0] and tag.
  - S2: 46-bit product p = a*b.
  - S3: first fold, using 2^23 ≡ 2^13 - 1 (mod q): t = p[22:0] + (p[45:23] << 13) - p[45:23]. Computed signed, at least 38 bits wide.
  - S4 (output register): second fold of t, then a conditional add/subtract of Q so the result lies in [0, Q). Comparisons use >=, so a value equal to Q maps to 0.
- Handshake:
  - Transfer in when in_valid_i && in_ready_o. Transfer out when out_valid_o && out_ready_i.
  - Each stage loads when it is empty or when its contents advance this cycle.
  - in_ready_o = !v1 || S1 advances. It is combinational from out_ready_i through the chain; there is no combinational path from in_valid_i to in_ready_o.
- Latency: an operation accepted at edge N is presented on out_valid_o in the cycle after edge N+3, provided there are no stalls.
- Throughput: 1 operation per cycle when out_ready_i is held at 1.
- Ordering: strictly in order; tag_o always belongs to result_o.
- Hold rules:
  - While out_valid_o = 1 and out_ready_i = 0, result_o and tag_o hold stable.
  - The pipeline holds at most 4 operations; with a full stall, in_ready_o is 0.
- Simultaneous events: accept and emit in the same cycle is legal and loses nothing.
- Reset mid-operation: all in-flight operations are dropped with no output, and in_ready_o = 1 in the first cycle after reset deasserts.
- busy_o = OR of all stage valid bits.
- Operands: values in [Q, 2^23) are still reduced correctly, because the product stays below 2^46.

Optional Feature:
- Macro: MULMOD_RANGE_CHECK_EN.
- Defined: on an accepted operation with a[22:0] >= Q or b[22:0] >= Q, err_o is set the following cycle. It stays high until reset. The result is still computed and emitted normally.
- Not defined: err_o is tied to 0 and no comparators are built.

Test Plan:
- a=0, b=12345, tag=0x01 -> result 0, tag_o 0x01, out_valid_o high exactly 4 cycles after acceptance.
- a=8380416, b=8380416 -> 1. a=8380416, b=3 -> 8380414. a=4096, b=2048 -> 8191.
- Back-to-back stream of 16 random pairs, out_ready_i=1 -> 16 results on consecutive cycles matching a golden (a*b)%8380417 model, tags in order.
- Stream 8 ops, out_ready_i=0 for 6 cycles -> in_ready_o drops after 4 accepted, result_o/tag_o stable during the stall, no loss or duplication after release.
- Assert rst_ni=0 for one cycle with 3 ops in flight -> out_valid_o=0 and busy_o=0 the next cycle, no stale results emitted afterwards.
- With MULMOD_RANGE_CHECK_EN: a=8388607, b=1 -> result 8190, err_o=1 and sticky. Without the macro, the same stimulus gives the same result and err_o=0.
